// File: rtl/nco_sweep_ctrl.sv
// Staircase sweep sequencer for the NCO phase increment (single, sawtooth, triangle).
// All outputs registered, one cycle after the triggering input; no backpressure, hold freezes dwell.
module nco_sweep_ctrl #(
  parameter int PHI_W   = 32,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHI_W-1:0]   cfg_start_phi_i,
  input  logic [PHI_W-1:0]   cfg_stop_phi_i,
  input  logic [PHI_W-1:0]   cfg_step_phi_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               hold_i,
  output logic [PHI_W-1:0]   phi_inc_o,
  output logic               step_stb_o,
  output logic               sweep_done_o,
  output logic               cfg_err_o,
  output logic               busy_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DWELL = 1'b1;
  localparam logic [1:0] M_SAW   = 2'd1;
  localparam logic [1:0] M_TRI   = 2'd2;

  logic [0:0]         state_q, state_d;
  logic               dir_up_q, dir_up_d;
  logic [PHI_W-1:0]   phi_q, phi_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [PHI_W-1:0]   start_sh_q, start_sh_d;
  logic [PHI_W-1:0]   stop_sh_q, stop_sh_d;
  logic [PHI_W-1:0]   step_sh_q, step_sh_d;
  logic [DWELL_W-1:0] dwell_sh_q, dwell_sh_d;
  logic [1:0]         mode_sh_q, mode_sh_d;
  logic               stb_q, stb_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [PHI_W:0]     sum_w;
  logic [PHI_W:0]     diff_w;
  logic [PHI_W-1:0]   up_nxt;
  logic [PHI_W-1:0]   dn_nxt;
  logic               cfg_bad;

  // One extra bit on both sides so the clamp sees carry/borrow instead of a wrapped value.
  assign sum_w   = {1'b0, phi_q} + {1'b0, step_sh_q};
  assign diff_w  = {1'b0, phi_q} - {1'b0, step_sh_q};
  assign up_nxt  = (sum_w > {1'b0, stop_sh_q}) ? stop_sh_q : sum_w[PHI_W-1:0];
  assign dn_nxt  = (diff_w[PHI_W] || (diff_w[PHI_W-1:0] < start_sh_q)) ? start_sh_q
                                                                       : diff_w[PHI_W-1:0];
  assign cfg_bad = (cfg_step_phi_i == '0) || (cfg_start_phi_i > cfg_stop_phi_i);

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    phi_d       = phi_q;
    dwell_cnt_d = dwell_cnt_q;
    start_sh_d  = start_sh_q;
    stop_sh_d   = stop_sh_q;
    step_sh_d   = step_sh_q;
    dwell_sh_d  = dwell_sh_q;
    mode_sh_d   = mode_sh_q;
    stb_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (abort_i) begin
      state_d     = S_IDLE;
      phi_d       = '0;
      dir_up_d    = 1'b1;
      dwell_cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      if (start_i) begin
        start_sh_d = cfg_start_phi_i;
        stop_sh_d  = cfg_stop_phi_i;
        step_sh_d  = cfg_step_phi_i;
        dwell_sh_d = cfg_dwell_i;
        mode_sh_d  = cfg_mode_i;
        if (cfg_bad) begin
          err_d = 1'b1;
        end else begin
          phi_d       = cfg_start_phi_i;
          stb_d       = 1'b1;
          dir_up_d    = 1'b1;
          dwell_cnt_d = cfg_dwell_i;
          state_d     = S_DWELL;
        end
      end
    end else if (!hold_i) begin
      if (dwell_cnt_q != '0) begin
        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
      end else begin
        dwell_cnt_d = dwell_sh_q;
        stb_d       = 1'b1;
        if (dir_up_q) begin
          if (phi_q != stop_sh_q) begin
            phi_d = up_nxt;
          end else begin
            case (mode_sh_q)
              M_SAW: phi_d = start_sh_q;
              M_TRI: begin
                dir_up_d = 1'b0;
                phi_d    = dn_nxt;
              end
              // single and the reserved encoding end here, leaving stop on the output
              default: begin
                stb_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            endcase
          end
        end else if (phi_q != start_sh_q) begin
          phi_d = dn_nxt;
        end else begin
          dir_up_d = 1'b1;
          phi_d    = up_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_up_q    <= 1'b1;
      phi_q       <= '0;
      dwell_cnt_q <= '0;
      start_sh_q  <= '0;
      stop_sh_q   <= '0;
      step_sh_q   <= '0;
      dwell_sh_q  <= '0;
      mode_sh_q   <= '0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      phi_q       <= phi_d;
      dwell_cnt_q <= dwell_cnt_d;
      start_sh_q  <= start_sh_d;
      stop_sh_q   <= stop_sh_d;
      step_sh_q   <= step_sh_d;
      dwell_sh_q  <= dwell_sh_d;
      mode_sh_q   <= mode_sh_d;
      stb_q       <= stb_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign phi_inc_o    = phi_q;
  assign step_stb_o   = stb_q;
  assign sweep_done_o = done_q;
  assign cfg_err_o    = err_q;
  assign busy_o       = (state_q == S_DWELL);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed scenarios plus random sweeps against a point-list reference model.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
  logic [23:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic        start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [31:0] phi_inc;
  logic        step_stb, sweep_done, cfg_err, busy;

  nco_sweep_ctrl #(.PHI_W(32), .DWELL_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start_phi_i(cfg_start), .cfg_stop_phi_i(cfg_stop), .cfg_step_phi_i(cfg_step),
    .cfg_dwell_i(cfg_dwell), .cfg_mode_i(cfg_mode),
    .start_i(start), .abort_i(abort), .hold_i(hold),
    .phi_inc_o(phi_inc), .step_stb_o(step_stb), .sweep_done_o(sweep_done),
    .cfg_err_o(cfg_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int stb_cnt = 0, done_cnt = 0, err_cnt = 0;

  // Reference model: the sweep is the ordered list of visited increments, walked by index.
  logic [31:0] pts[$];
  bit          m_busy = 0, m_stb = 0, m_done = 0, m_err = 0;
  logic [31:0] m_phi = '0;
  int          m_idx = 0, m_rem = 0, m_dwell = 0;
  logic [1:0]  m_mode = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void build(longint s, longint e, longint st, logic [1:0] md);
    longint v;
    pts.delete();
    v = s;
    pts.push_back(32'(v));
    while (v != e) begin
      v = (v + st > e) ? e : v + st;
      pts.push_back(32'(v));
    end
    if (md == 2'd2) begin
      v = e;
      forever begin
        v = (v - st < s) ? s : v - st;
        if (v == s) break;
        pts.push_back(32'(v));
      end
    end
  endfunction

  task automatic model_step();
    m_stb = 0; m_done = 0; m_err = 0;
    if (!rst_n || abort) begin
      m_busy = 0;
      m_phi  = '0;
    end else if (!m_busy) begin
      if (start) begin
        if (cfg_step == 0 || cfg_start > cfg_stop) begin
          m_err = 1;
        end else begin
          build(longint'(cfg_start), longint'(cfg_stop), longint'(cfg_step), cfg_mode);
          m_mode = cfg_mode; m_dwell = int'(cfg_dwell);
          m_idx = 0; m_phi = pts[0]; m_rem = m_dwell + 1; m_stb = 1; m_busy = 1;
        end
      end
    end else if (!hold) begin
      m_rem--;
      if (m_rem == 0) begin
        if ((m_mode == 2'd0 || m_mode == 2'd3) && m_idx == pts.size() - 1) begin
          m_done = 1; m_busy = 0;
        end else begin
          m_idx = (m_idx + 1) % pts.size();
          m_phi = pts[m_idx]; m_stb = 1; m_rem = m_dwell + 1;
        end
      end
    end
  endtask

  task automatic check_outputs(string tag);
    check({tag, ".phi"},  phi_inc,    m_phi);
    check({tag, ".stb"},  step_stb,   m_stb);
    check({tag, ".done"}, sweep_done, m_done);
    check({tag, ".err"},  cfg_err,    m_err);
    check({tag, ".busy"}, busy,       m_busy);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    if (step_stb) stb_cnt++;
    if (sweep_done) done_cnt++;
    if (cfg_err) err_cnt++;
    @(negedge clk);
  endtask

  task automatic set_cfg(logic [31:0] s, logic [31:0] e, logic [31:0] st, logic [23:0] dw,
                         logic [1:0] md);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = md;
  endtask

  task automatic pulse_start(string tag);
    start = 1'b1; tick(tag); start = 1'b0;
    cfg_start = $urandom; cfg_stop = $urandom; cfg_step = $urandom; cfg_mode = 2'($urandom);
  endtask

  task automatic run_until_idle(string tag, int budget);
    int k = 0;
    while (m_busy && k < budget) begin tick(tag); k++; end
    check({tag, ".timeout"}, m_busy, 0);
  endtask

  task automatic do_abort(string tag);
    abort = 1'b1; tick(tag); abort = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    // single staircase, endpoints exact
    set_cfg(100, 130, 10, 2, 2'd0);
    stb_cnt = 0; done_cnt = 0;
    pulse_start("t1");
    run_until_idle("t1", 40);
    check("t1.stb_cnt", stb_cnt, 4);
    check("t1.done_cnt", done_cnt, 1);
    tick("t1.after");
    check("t1.phi_holds_stop", phi_inc, 130);

    // top of range: sum must not wrap
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 2'd0);
    pulse_start("t2");
    run_until_idle("t2", 10);
    check("t2.phi_end", phi_inc, 32'hFFFF_FFFF);

    // triangle never completes
    set_cfg(10, 30, 10, 0, 2'd2);
    done_cnt = 0;
    pulse_start("t3");
    for (int i = 0; i < 30; i++) tick("t3");
    check("t3.no_done", done_cnt, 0);
    do_abort("t3.abort");

    // start==stop sawtooth, with a hold window
    set_cfg(5, 5, 7, 1, 2'd1);
    pulse_start("t4");
    for (int i = 0; i < 5; i++) tick("t4");
    hold = 1'b1;
    for (int i = 0; i < 4; i++) tick("t4.hold");
    hold = 1'b0;
    for (int i = 0; i < 6; i++) tick("t4");

    // abort and start together while busy, then a clean restart
    done_cnt = 0;
    abort = 1'b1; start = 1'b1; tick("t5.abort"); abort = 1'b0; start = 1'b0;
    check("t5.phi_zero", phi_inc, 0);
    check("t5.not_busy", busy, 0);
    set_cfg(200, 260, 25, 1, 2'd0);
    pulse_start("t5.restart");
    run_until_idle("t5.restart", 40);
    check("t5.one_done", done_cnt, 1);

    // rejected configs
    err_cnt = 0;
    set_cfg(50, 90, 0, 1, 2'd0);
    pulse_start("t6.step0");
    set_cfg(50, 40, 5, 1, 2'd0);
    pulse_start("t6.order");
    tick("t6.idle");
    check("t6.err_cnt", err_cnt, 2);
    check("t6.phi_kept", phi_inc, 260);

    // reset in the middle of a sweep
    set_cfg(1000, 5000, 300, 3, 2'd1);
    pulse_start("rst.sweep");
    for (int i = 0; i < 9; i++) tick("rst.sweep");
    rst_n = 1'b0;
    #1;
    m_busy = 0; m_phi = '0; m_stb = 0; m_done = 0; m_err = 0;
    check_outputs("rst.async");
    tick("rst.held");
    rst_n = 1'b1;
    tick("rst.released");

    // random sweeps
    for (int t = 0; t < 40; t++) begin
      longint st, span, s;
      int ncyc;
      st   = longint'($urandom_range(1, 1000));
      span = st * longint'($urandom_range(0, 6)) + longint'($urandom_range(0, 999)) % st;
      if ($urandom_range(0, 3) == 0)
        s = 64'hFFFF_FFFF - span - longint'($urandom_range(0, 3));
      else
        s = longint'($urandom_range(0, 32'h7FFF_FFFF));
      set_cfg(32'(s), 32'(s + span), 32'(st), 24'($urandom_range(0, 3)), 2'($urandom));
      if ($urandom_range(0, 9) == 0) cfg_step = '0;
      else if ($urandom_range(0, 9) == 0 && span > 0) cfg_start = cfg_stop + 32'd1;
      pulse_start("rnd.start");
      ncyc = $urandom_range(20, 150);
      for (int i = 0; i < ncyc && m_busy; i++) begin
        hold  = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 99) == 0);
        start = m_busy && ($urandom_range(0, 19) == 0);
        tick("rnd");
      end
      hold = 1'b0; start = 1'b0; abort = 1'b0;
      if (m_busy) do_abort("rnd.abort");
      tick("rnd.idle");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
